clk_sel_ctrl: RTL and testbench

//  Select controller that drives the select input of the clock-mux block.

---
 rtl/clk_sel_pkg.sv | 19 +
 rtl/clk_freq_mon.sv | 86 ++++++++
 rtl/clk_sel_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// Shared state encoding and helpers for the clock select controller.
// Latency: n/a (types and functions only).
// Backpressure: none.
package clk_sel_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_RUN0 = 2'b00,
    ST_RUN1 = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // RUN state that corresponds to a given select value
  function automatic state_e run_state(input logic sel);
    return sel ? ST_RUN1 : ST_RUN0;
  endfunction

endpackage

// File: rtl/clk_freq_mon.sv
// Per-candidate frequency monitor: sync, edge count per window, range check, qualification.
// Latency: edge counted 3 clk_i after the toggle; cnt_o/ok_o update on the cycle after win_end_i.
// Backpressure: none; free-running measurement.
module clk_freq_mon #(
  parameter int CNT_W     = 16,
  parameter int MIN_EDGES = 200,
  parameter int MAX_EDGES = 312,
  parameter int GOOD_WINS = 4
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             tog_i,
  input  logic             win_end_i,
  output logic             ok_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int RUN_W = $clog2(GOOD_WINS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] MIN_C = MIN_EDGES;
  localparam logic [31:0] MAX_C = MAX_EDGES;
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(GOOD_WINS);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             tog_edge;
  logic [31:0]      cnt_ext;
  logic             in_range;

  // Any level change of the synchronised toggle is one edge of the candidate clock
  assign tog_edge = sync_q ^ prev_q;
  // Range check is applied to the count being latched at the window end
  assign cnt_ext  = 32'(edge_cnt_q);
  assign in_range = (cnt_ext >= MIN_C) && (cnt_ext <= MAX_C);

  // Next-state: synchroniser, saturating edge counter, window latch, good-window run length
  always_comb begin
    meta_d     = tog_i;
    sync_d     = meta_q;
    prev_d     = sync_q;
    edge_cnt_d = edge_cnt_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    if (win_end_i) begin
      // An edge landing on the terminal cycle belongs to the next window
      edge_cnt_d = tog_edge ? CNT_W'(1) : '0;
      cnt_d      = edge_cnt_q;
      if (in_range) begin
        if (run_q != RUN_FULL) begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        run_d = '0;
      end
    end else if (tog_edge && (edge_cnt_q != CNT_MAX)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      edge_cnt_q <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
    end
  end

  assign ok_o  = (run_q == RUN_FULL);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-mux select controller: qualifies two candidates and drives a registered, non-revertive select.
// Latency: select flips one cycle after the decision; HOLD then blocks changes for HOLDOFF cycles.
// Backpressure: none; force requests and failures seen in HOLD are acted on in the first RUN cycle.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = 16,
  parameter int MIN_EDGES  = 200,
  parameter int MAX_EDGES  = 312,
  parameter int GOOD_WINS  = 4,
  parameter int HOLDOFF    = 64,
  parameter bit PRIMARY    = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             tog0_i,
  input  logic             tog1_i,
  input  logic             force_en_i,
  input  logic             force_sel_i,
  output logic             sel_o,
  output logic             switch_pulse_o,
  output logic             clk0_ok_o,
  output logic             clk1_ok_o,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o,
  output logic [ST_W-1:0]  state_o
);

  localparam int WIN_W  = $clog2(WIN_CYCLES);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              pulse_q, pulse_d;
  logic              win_end;
  logic              ok0, ok1;
  logic              ok_cur, ok_oth;
  logic              desired;

  assign win_end = (win_cnt_q == WIN_LAST);

  clk_freq_mon #(
    .CNT_W    (CNT_W),
    .MIN_EDGES(MIN_EDGES),
    .MAX_EDGES(MAX_EDGES),
    .GOOD_WINS(GOOD_WINS)
  ) u_mon0 (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .tog_i    (tog0_i),
    .win_end_i(win_end),
    .ok_o     (ok0),
    .cnt_o    (cnt0_o)
  );

  clk_freq_mon #(
    .CNT_W    (CNT_W),
    .MIN_EDGES(MIN_EDGES),
    .MAX_EDGES(MAX_EDGES),
    .GOOD_WINS(GOOD_WINS)
  ) u_mon1 (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .tog_i    (tog1_i),
    .win_end_i(win_end),
    .ok_o     (ok1),
    .cnt_o    (cnt1_o)
  );

  // Shared measurement window: wraps at the terminal count
  always_comb begin
    win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
  end

  // Desired select: force wins, otherwise stay on a healthy candidate, fail over only to a healthy one
  always_comb begin
    ok_cur  = sel_q ? ok1 : ok0;
    ok_oth  = sel_q ? ok0 : ok1;
    desired = sel_q;
    if (force_en_i) begin
      desired = force_sel_i;
    end else if (!ok_cur && ok_oth) begin
      desired = ~sel_q;
    end
  end

  // FSM next-state and select/pulse/holdoff updates
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pulse_d    = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_RUN0, ST_RUN1: begin
        if (desired != sel_q) begin
          sel_d      = desired;
          pulse_d    = 1'b1;
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = run_state(sel_q);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = run_state(sel_q);
      end
    endcase
  end

  // State registers; reset restarts the window and returns to the primary candidate
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= run_state(PRIMARY);
      sel_q      <= PRIMARY;
      pulse_q    <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      pulse_q    <= pulse_d;
    end
  end

  assign sel_o          = sel_q;
  assign switch_pulse_o = pulse_q;
  assign clk0_ok_o      = ok0;
  assign clk1_ok_o      = ok1;
  assign state_o        = state_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Randomised window-level bench for clk_sel_ctrl with a queue-based scoreboard.
// Latency: expectations are checked mid-window, well after any holdoff has expired.
// Backpressure: n/a.
module tb_clk_sel_ctrl;

  localparam int WIN  = 1024;
  localparam int GOOD = 4;
  localparam int HOLD = 64;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        tog0_i = 1'b0;
  logic        tog1_i = 1'b0;
  logic        force_en_i = 1'b0;
  logic        force_sel_i = 1'b0;
  logic        sel_o, switch_pulse_o, clk0_ok_o, clk1_ok_o;
  logic [15:0] cnt0_o, cnt1_o;
  logic [1:0]  state_o;
  logic        sel8, pulse8, ok08, ok18;
  logic [7:0]  c08, c18;
  logic [1:0]  st8;

  clk_sel_ctrl u_dut (
    .clk_i(clk_i), .arst_i(arst_i), .tog0_i(tog0_i), .tog1_i(tog1_i),
    .force_en_i(force_en_i), .force_sel_i(force_sel_i),
    .sel_o(sel_o), .switch_pulse_o(switch_pulse_o),
    .clk0_ok_o(clk0_ok_o), .clk1_ok_o(clk1_ok_o),
    .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .state_o(state_o)
  );

  clk_sel_ctrl #(.CNT_W(8)) u_dut8 (
    .clk_i(clk_i), .arst_i(arst_i), .tog0_i(tog0_i), .tog1_i(tog1_i),
    .force_en_i(force_en_i), .force_sel_i(force_sel_i),
    .sel_o(sel8), .switch_pulse_o(pulse8),
    .clk0_ok_o(ok08), .clk1_ok_o(ok18),
    .cnt0_o(c08), .cnt1_o(c18), .state_o(st8)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (window granularity) ----------------
  typedef struct {
    int due;
    int cnt0; int cnt1; int cnt08; int cnt18;
    bit ok0;  bit ok1;  bit sel;   int pulses;
  } exp_t;

  exp_t exp_q[$];
  bit   m_hist0[$];
  bit   m_hist1[$];
  int   m_cnt0, m_cnt1;
  bit   m_sel;
  int   m_pulses = 0;
  bit   m_fresh;
  bit   m_sw_pending;

  function automatic bit in_range(input int n);
    return (n >= 200) && (n <= 312);
  endfunction

  function automatic int min255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Qualified means the last GOOD windows were all in range
  function automatic bit m_ok(input int which);
    int n;
    n = (which != 0) ? m_hist1.size() : m_hist0.size();
    if (n < GOOD) return 1'b0;
    for (int i = n - GOOD; i < n; i++) begin
      if (((which != 0) ? m_hist1[i] : m_hist0[i]) == 1'b0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply the selection rules once; returns 1 if the select moved
  function automatic bit m_step();
    bit d;
    if (force_en_i) d = force_sel_i;
    else if (m_ok(m_sel ? 1 : 0)) d = m_sel;
    else if (m_ok(m_sel ? 0 : 1)) d = ~m_sel;
    else d = m_sel;
    if (d != m_sel) begin
      m_sel = d;
      m_pulses++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_hist0.delete();
    m_hist1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_sel = 1'b0;
    m_fresh = 1'b1;
    m_sw_pending = 1'b0;
  endtask

  task automatic model_window_end(input int n0, input int n1);
    m_cnt0 = n0;
    m_cnt1 = n1;
    m_hist0.push_back(in_range(n0));
    m_hist1.push_back(in_range(n1));
    m_sw_pending = m_step();
    m_fresh = 1'b0;
  endtask

  function automatic int pick_n(input int cat);
    case (cat)
      0: return 0;
      1: return $urandom_range(1, 199);
      2: return $urandom_range(200, 312);
      3: return $urandom_range(313, 320);
      4: return 199;
      5: return 200;
      6: return 312;
      7: return 313;
      default: return $urandom_range(256, 320);
    endcase
  endfunction

  function automatic int pick_sp(input int n);
    int mx;
    if (n == 0) return 8;
    mx = 960 / n;
    if (mx > 8) mx = 8;
    if (mx < 3) mx = 3;
    return $urandom_range(3, mx);
  endfunction

  // ---------------- select-change / pulse / holdoff checker ----------------
  bit prev_sel = 1'b0;
  int last_chg = 0;
  int last_gap = 0;
  int hold_run = 0;
  int pulse_seen = 0;

  always @(negedge clk_i) begin
    bit chg;
    if (arst_i) begin
      prev_sel = sel_o;
      hold_run = 0;
      last_chg = cyc;
    end else begin
      chg = (sel_o != prev_sel);
      if (switch_pulse_o) pulse_seen++;
      if (chg || switch_pulse_o) check("pulse_vs_change", switch_pulse_o, chg);
      if (chg) begin
        last_gap = cyc - last_chg;
        last_chg = cyc;
        prev_sel = sel_o;
      end
      if (state_o == 2'b10) begin
        hold_run++;
      end else if (hold_run > 0) begin
        check("hold_len", hold_run, HOLD);
        hold_run = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        e = exp_q.pop_front();
        check("cnt0", cnt0_o, e.cnt0);
        check("cnt1", cnt1_o, e.cnt1);
        check("cnt0_w8", c08, e.cnt08);
        check("cnt1_w8", c18, e.cnt18);
        check("ok0", clk0_ok_o, e.ok0);
        check("ok1", clk1_ok_o, e.ok1);
        check("sel", sel_o, e.sel);
        check("state_run", state_o, e.sel ? 1 : 0);
        check("pulse_total", pulse_seen, e.pulses);
      end
    end
  end

  // ---------------- stimulus ----------------
  // act: 0 none, 1 random force, 2 release force, 3 force flip then reverse in HOLD, 4 reset in HOLD
  task automatic run_window(input int n0, input int n1, input int act);
    int sp0, sp1, k0, k1;
    exp_t e;
    sp0 = pick_sp(n0);
    sp1 = pick_sp(n1);
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk_i);
      if (c == 0 && !m_fresh) begin
        check("sel_at_win_start", sel_o, m_sel);
        check("pulse_at_win_start", switch_pulse_o, m_sw_pending);
      end
      if (k0 < n0 && c >= 20 && ((c - 20) % sp0) == 0) begin
        tog0_i = ~tog0_i;
        k0++;
      end
      if (k1 < n1 && c >= 20 && ((c - 20) % sp1) == 0) begin
        tog1_i = ~tog1_i;
        k1++;
      end
      if (c == 500 && act != 0) begin
        case (act)
          1: begin force_en_i = 1'b1; force_sel_i = 1'($urandom_range(0, 1)); end
          2: force_en_i = 1'b0;
          default: begin force_en_i = 1'b1; force_sel_i = ~m_sel; end
        endcase
        void'(m_step());
      end
      if (c == 501 && act != 0) check("sel_after_force", sel_o, m_sel);
      if (c == 510 && act == 3) begin
        force_sel_i = ~force_sel_i;
        void'(m_step());
      end
      if (c == 520 && act == 4) begin
        #2 arst_i = 1'b1;
        tog0_i = 1'b0;
        tog1_i = 1'b0;
        force_en_i = 1'b0;
        force_sel_i = 1'b0;
        #1;
        check("rst_sel", sel_o, 0);
        check("rst_state", state_o, 0);
        check("rst_ok", {clk0_ok_o, clk1_ok_o}, 0);
        check("rst_cnt0", cnt0_o, 0);
        check("rst_cnt1", cnt1_o, 0);
        check("rst_pulse", switch_pulse_o, 0);
        @(negedge clk_i);
        #2 arst_i = 1'b0;
        model_reset();
        return;
      end
      if (c == 600) begin
        e.due = cyc + 100;
        e.cnt0 = m_cnt0;  e.cnt1 = m_cnt1;
        e.cnt08 = min255(m_cnt0);  e.cnt18 = min255(m_cnt1);
        e.ok0 = m_ok(0);  e.ok1 = m_ok(1);
        e.sel = m_sel;    e.pulses = m_pulses;
        exp_q.push_back(e);
      end
      if (c == 700 && act == 3) check("hold_then_switch_gap", last_gap, HOLD + 1);
    end
    model_window_end(n0, n1);
  endtask

  // Window plan: {category for tog0, category for tog1, action}
  int plan [][3] = '{
    '{2,0,0}, '{5,0,0}, '{6,0,0}, '{2,0,0},   // candidate 0 qualifies, sel stays 0
    '{2,2,0}, '{2,5,0}, '{2,6,0}, '{2,2,0},   // candidate 1 qualifies too
    '{1,2,0},                                  // candidate 0 fails -> switch to 1
    '{2,2,0}, '{0,4,0}, '{0,0,0},              // both fail: select holds, no pulse
    '{8,7,1}, '{2,2,3}, '{3,8,2},              // force, reversal inside HOLD, release
    '{2,2,4},                                  // reset during HOLD
    '{2,1,0}, '{2,2,0}, '{2,2,0}, '{2,2,0}, '{2,2,0}
  };

  initial begin
    model_reset();
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_sel", sel_o, 0);
    check("reset_state", state_o, 0);
    check("reset_cnt0", cnt0_o, 0);
    check("reset_ok0", clk0_ok_o, 0);
    #1 arst_i = 1'b0;
    foreach (plan[i]) run_window(pick_n(plan[i][0]), pick_n(plan[i][1]), plan[i][2]);
    for (int i = 0; i < 6; i++) begin
      run_window(pick_n($urandom_range(0, 8)), pick_n($urandom_range(0, 8)), $urandom_range(0, 2));
    end
    run_window(0, 0, 0);
    repeat (200) @(negedge clk_i);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
